stopwatch_lap_buffer: RTL and testbench
=======================================

# stopwatch_lap_buffer

Lap/split recorder between `stopwatch_dp` and `fnd_controller`. It captures the running stopwatch time on a lap pulse into a DEPTH-entry ring buffer. It forwards either the live time or a recalled lap to the display. A hold timer returns the display to live time after a recall.

## Interface
- `DEPTH`, 4, number of lap entries; power of two, ≥2.
- `HOLD_CYCLES`, 200_000_000, clk cycles a recalled lap stays on display without a further recall (2 s at 100 MHz).
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous active-low reset.
- `i_lap`  input  1  one-cycle pulse (debounced, edge-detected) requesting a lap capture.
- `i_recall`  input  1  one-cycle pulse: show the next stored lap.
- `i_clear`  input  1  one-cycle pulse: erase all laps, return to live.
- `msec`  input  7  live hundredths, 0–99.
- `sec`  input  6  live seconds, 0–59.
- `min`  input  6  live minutes, 0–59.
- `hour`  input  5  live hours, 0–23.
- `o_msec`, `o_sec`, `o_min`, `o_hour`  output  7/6/6/5  time presented to `fnd_controller`.
- `o_lap_count`  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- `o_full`  output  1  `o_lap_count == DEPTH`.
- `o_view_idx`  output  $clog2(DEPTH)  entry shown, as an offset from the oldest entry (0 = oldest); 0 in LIVE.
- `o_showing_lap`  output  1  high in VIEW state.

## Operation
- Storage:
  - Each entry is the packed 24-bit word {hour,min,sec,msec}.
  - Write pointer `wp` and count `cnt`. Oldest entry = (wp − cnt) mod DEPTH.
- Capture (`i_lap`):
  - Writes the current inputs at `wp` and sets wp ← wp+1 mod DEPTH.
  - If cnt<DEPTH, cnt ← cnt+1. Otherwise the oldest entry is overwritten and cnt stays DEPTH.
- FSM states: LIVE, VIEW.
  - LIVE: outputs follow the live inputs. `i_recall` with cnt>0 → VIEW with view_idx=0 and hold timer cleared. `i_recall` with cnt=0 is ignored.
  - VIEW: outputs show entry (oldest+view_idx).
    - `i_recall` with view_idx<cnt−1: view_idx+1 and the hold timer is cleared.
    - `i_recall` with view_idx=cnt−1 → LIVE.
    - Hold timer reaching HOLD_CYCLES−1 → LIVE.
    - `i_lap` in VIEW: the capture is performed and the FSM goes to LIVE.
- `i_clear`: cnt←0, wp←0, FSM→LIVE, view_idx←0. Memory contents need not be erased.
- Priority within one cycle: `i_clear` > `i_lap` > `i_recall`.
  - `i_clear` with anything: only the clear takes effect.
  - `i_lap` with `i_recall` in LIVE: the lap is captured and the recall is ignored.
- Reset, asynchronous on `rst`=0:
  - cnt=0, wp=0, state LIVE, view_idx=0, timer=0.
  - All outputs 0: o_msec/o_sec/o_min/o_hour=0, o_lap_count=0, o_full=0, o_view_idx=0, o_showing_lap=0.
- No range checking of the inputs; values are stored and forwarded bit-exact.

## Timing
- All outputs are registered.
- In LIVE, the o_ time equals the inputs sampled on the previous rising edge (1-cycle latency).
- After an `i_lap` pulse in cycle N, o_lap_count/o_full update at the edge ending cycle N, so they are visible in N+1.
- The captured value is the input sampled in cycle N.
- After an `i_recall` pulse in cycle N, o_showing_lap, o_view_idx and the lap time are visible in N+1.
- Storage is registers (or LUTRAM with asynchronous read), so there is no extra read latency.
- Hold timeout:
  - The timer counts every cycle in VIEW.
  - If the last recall was in cycle N, the FSM is LIVE (o_showing_lap=0) in cycle N+HOLD_CYCLES+1, with live time visible from the same cycle.
- Back-to-back pulses on consecutive cycles are all honoured; there is no dead time.

## Test plan
Unless stated otherwise, DEPTH=4 and HOLD_CYCLES=10.
- Reset mid-VIEW:
  - Stimulus: 2 laps, recall, then assert `rst` low asynchronously between edges.
  - Required: all outputs 0 immediately. After release, o_lap_count=0 and o_showing_lap=0.
- Capture/recall order:
  - Stimulus: laps at 00:00:01.10, 00:00:02.20, 00:00:03.30, then recall ×4.
  - Required: displays 01.10 (idx0), 02.20 (idx1), 03.30 (idx2), then live (o_showing_lap=0); o_lap_count=3.
- Wrap/overwrite:
  - Stimulus: 5 laps with msec=11,22,33,44,55, then recall.
  - Required: o_full=1, o_lap_count=4, first recalled msec=22, last recalled msec=55.
- Hold timeout:
  - Stimulus: 1 lap, recall in cycle N.
  - Required: lap shown in cycles N+1..N+HOLD_CYCLES; live time and o_showing_lap=0 in cycle N+11.
- Simultaneous events:
  - Stimulus 1: `i_clear`+`i_lap` together. Required: o_lap_count=0.
  - Stimulus 2: `i_lap`+`i_recall` in LIVE. Required: o_lap_count+1, o_showing_lap stays 0.
  - Stimulus 3: recall with an empty buffer. Required: ignored.
- Lap during VIEW:
  - Stimulus: 2 laps, recall, then `i_lap`.
  - Required: o_lap_count=3, FSM LIVE next cycle, the new entry holds the inputs of the lap cycle.

Source files
------------

// File: rtl/stopwatch_lap_buffer_if.sv
// Signal bundle between the stopwatch datapath, the lap buffer and the display driver.
// The slave modport is the lap buffer; the master modport is the upstream driver.
interface stopwatch_lap_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic            i_lap;
    logic            i_recall;
    logic            i_clear;
    logic [6:0]      msec;
    logic [5:0]      sec;
    logic [5:0]      min;
    logic [4:0]      hour;
    logic [6:0]      o_msec;
    logic [5:0]      o_sec;
    logic [5:0]      o_min;
    logic [4:0]      o_hour;
    logic [CntW-1:0] o_lap_count;
    logic            o_full;
    logic [IdxW-1:0] o_view_idx;
    logic            o_showing_lap;

    modport master (
        output i_lap, i_recall, i_clear, msec, sec, min, hour,
        input  o_msec, o_sec, o_min, o_hour, o_lap_count, o_full, o_view_idx, o_showing_lap
    );

    modport slave (
        input  i_lap, i_recall, i_clear, msec, sec, min, hour,
        output o_msec, o_sec, o_min, o_hour, o_lap_count, o_full, o_view_idx, o_showing_lap
    );
endinterface

// File: rtl/stopwatch_lap_buffer.sv
// Lap/split recorder: captures stopwatch time into a ring buffer and forwards either
// live time or a recalled lap to the display, reverting to live after a hold timeout.
module stopwatch_lap_buffer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 200_000_000
) (
    input logic                    clk,
    input logic                    rst,
    stopwatch_lap_buffer_if.slave  bus
);
    localparam int unsigned CntW   = $clog2(DEPTH + 1);
    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam int unsigned TimerW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [0:0] {StLive, StView} state_e;

    logic [23:0]       mem_q [DEPTH];
    state_e            state_q, state_d;
    logic [IdxW-1:0]   wp_q, wp_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   view_idx_q, view_idx_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [23:0]       time_q, time_d;
    logic              full_q, showing_q;
    logic              we;
    logic [23:0]       live_word;
    logic [IdxW-1:0]   oldest;

    assign live_word = {bus.hour, bus.min, bus.sec, bus.msec};
    // With cnt == DEPTH the low bits are zero, so oldest lands on wp as required.
    assign oldest    = wp_q - cnt_q[IdxW-1:0];

    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        view_idx_d = view_idx_q;
        timer_d    = timer_q;
        we         = 1'b0;
        if (bus.i_clear) begin
            state_d    = StLive;
            wp_d       = '0;
            cnt_d      = '0;
            view_idx_d = '0;
            timer_d    = '0;
        end else if (bus.i_lap) begin
            we         = 1'b1;
            wp_d       = wp_q + IdxW'(1);
            if (cnt_q < CntW'(DEPTH)) cnt_d = cnt_q + CntW'(1);
            state_d    = StLive;
            view_idx_d = '0;
            timer_d    = '0;
        end else if (bus.i_recall) begin
            timer_d = '0;
            if (state_q == StLive) begin
                if (cnt_q != '0) begin
                    state_d    = StView;
                    view_idx_d = '0;
                end
            end else if ((CntW'(view_idx_q) + CntW'(1)) < cnt_q) begin
                view_idx_d = view_idx_q + IdxW'(1);
            end else begin
                state_d    = StLive;
                view_idx_d = '0;
            end
        end else if (state_q == StView) begin
            if (timer_q == TimerW'(HOLD_CYCLES - 1)) begin
                state_d    = StLive;
                view_idx_d = '0;
                timer_d    = '0;
            end else begin
                timer_d = timer_q + TimerW'(1);
            end
        end

        // Staying in VIEW implies no write this cycle, so current wp/cnt/mem are valid.
        time_d = (state_d == StView) ? mem_q[oldest + view_idx_d] : live_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StLive;
            wp_q       <= '0;
            cnt_q      <= '0;
            view_idx_q <= '0;
            timer_q    <= '0;
            time_q     <= '0;
            full_q     <= 1'b0;
            showing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
            view_idx_q <= view_idx_d;
            timer_q    <= timer_d;
            time_q     <= time_d;
            full_q     <= (cnt_d == CntW'(DEPTH));
            showing_q  <= (state_d == StView);
        end
    end

    // Lap storage carries no reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (we) mem_q[wp_q] <= live_word;
    end

    assign bus.o_hour        = time_q[23:19];
    assign bus.o_min         = time_q[18:13];
    assign bus.o_sec         = time_q[12:7];
    assign bus.o_msec        = time_q[6:0];
    assign bus.o_lap_count   = cnt_q;
    assign bus.o_full        = full_q;
    assign bus.o_view_idx    = view_idx_q;
    assign bus.o_showing_lap = showing_q;
endmodule

// File: tb/tb_stopwatch_lap_buffer.sv
// Directed bench for stopwatch_lap_buffer with DEPTH=4 and HOLD_CYCLES=10.
module tb_stopwatch_lap_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stopwatch_lap_buffer_if #(.DEPTH(4)) bus ();

    stopwatch_lap_buffer #(
        .DEPTH       (4),
        .HOLD_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns just after the next rising edge, so outputs reflect the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int ms);
        bus.hour = 5'(h);
        bus.min  = 6'(m);
        bus.sec  = 6'(s);
        bus.msec = 7'(ms);
    endtask

    task automatic pulse(input logic lap, input logic recall, input logic clear);
        bus.i_lap    = lap;
        bus.i_recall = recall;
        bus.i_clear  = clear;
        step();
        bus.i_lap    = 1'b0;
        bus.i_recall = 1'b0;
        bus.i_clear  = 1'b0;
    endtask

    function automatic logic [31:0] all_out();
        return {bus.o_hour, bus.o_min, bus.o_sec, bus.o_msec, bus.o_lap_count,
                bus.o_full, bus.o_view_idx, bus.o_showing_lap};
    endfunction

    initial begin
        bus.i_lap = 1'b0;
        bus.i_recall = 1'b0;
        bus.i_clear = 1'b0;
        set_time(3, 4, 5, 6);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", all_out(), 32'h0);
        rst = 1'b1;
        step();
        check_eq("live_latency", {bus.o_hour, bus.o_min, bus.o_sec, bus.o_msec},
                 {5'd3, 6'd4, 6'd5, 7'd6});
        check_eq("count_after_reset", bus.o_lap_count, 0);

        // Capture/recall order
        set_time(0, 0, 1, 10); pulse(1, 0, 0);
        set_time(0, 0, 2, 20); pulse(1, 0, 0);
        set_time(0, 0, 3, 30); pulse(1, 0, 0);
        check_eq("order_count", bus.o_lap_count, 3);
        check_eq("order_not_full", bus.o_full, 0);
        set_time(5, 6, 7, 8);
        pulse(0, 1, 0);
        check_eq("order_r1", {bus.o_showing_lap, bus.o_view_idx, bus.o_sec, bus.o_msec},
                 {1'b1, 2'd0, 6'd1, 7'd10});
        pulse(0, 1, 0);
        check_eq("order_r2", {bus.o_showing_lap, bus.o_view_idx, bus.o_sec, bus.o_msec},
                 {1'b1, 2'd1, 6'd2, 7'd20});
        pulse(0, 1, 0);
        check_eq("order_r3", {bus.o_showing_lap, bus.o_view_idx, bus.o_sec, bus.o_msec},
                 {1'b1, 2'd2, 6'd3, 7'd30});
        pulse(0, 1, 0);
        check_eq("order_r4_live", {bus.o_showing_lap, bus.o_view_idx, bus.o_hour, bus.o_msec},
                 {1'b0, 2'd0, 5'd5, 7'd8});
        check_eq("order_count_kept", bus.o_lap_count, 3);
        pulse(0, 0, 1);
        check_eq("clear_count", bus.o_lap_count, 0);

        // Wrap/overwrite
        for (int i = 1; i <= 5; i++) begin
            set_time(0, 0, 0, 11 * i);
            pulse(1, 0, 0);
        end
        check_eq("wrap_full", bus.o_full, 1);
        check_eq("wrap_count", bus.o_lap_count, 4);
        set_time(0, 0, 0, 0);
        pulse(0, 1, 0);
        check_eq("wrap_first", bus.o_msec, 22);
        repeat (3) pulse(0, 1, 0);
        check_eq("wrap_last", {bus.o_view_idx, bus.o_msec}, {2'd3, 7'd55});
        pulse(0, 1, 0);
        check_eq("wrap_back_live", bus.o_showing_lap, 0);
        pulse(0, 0, 1);
        check_eq("wrap_clear_full", bus.o_full, 0);

        // Hold timeout: recall in cycle N, lap shown N+1..N+10, live in N+11
        set_time(0, 0, 0, 77); pulse(1, 0, 0);
        set_time(0, 0, 0, 9);
        pulse(0, 1, 0);
        check_eq("hold_n1", {bus.o_showing_lap, bus.o_msec}, {1'b1, 7'd77});
        for (int k = 2; k <= 10; k++) begin
            step();
            check_eq($sformatf("hold_n%0d", k), {bus.o_showing_lap, bus.o_msec}, {1'b1, 7'd77});
        end
        step();
        check_eq("hold_n11_live", {bus.o_showing_lap, bus.o_msec}, {1'b0, 7'd9});
        pulse(0, 0, 1);

        // Simultaneous events
        pulse(0, 1, 0);
        check_eq("recall_empty", {bus.o_showing_lap, bus.o_lap_count}, {1'b0, 3'd0});
        pulse(1, 0, 0);
        pulse(1, 0, 1);
        check_eq("clear_beats_lap", bus.o_lap_count, 0);
        pulse(1, 1, 0);
        check_eq("lap_beats_recall", {bus.o_showing_lap, bus.o_lap_count}, {1'b0, 3'd1});
        pulse(0, 0, 1);

        // Lap during VIEW
        set_time(0, 0, 0, 1); pulse(1, 0, 0);
        set_time(0, 0, 0, 2); pulse(1, 0, 0);
        pulse(0, 1, 0);
        check_eq("view_entered", bus.o_showing_lap, 1);
        set_time(0, 0, 9, 63);
        pulse(1, 0, 0);
        check_eq("view_lap", {bus.o_showing_lap, bus.o_lap_count, bus.o_msec},
                 {1'b0, 3'd3, 7'd63});
        set_time(0, 0, 0, 0);
        repeat (3) pulse(0, 1, 0);
        check_eq("view_lap_entry", {bus.o_view_idx, bus.o_sec, bus.o_msec},
                 {2'd2, 6'd9, 7'd63});

        // Reset mid-VIEW, asserted between edges
        pulse(0, 0, 1);
        set_time(1, 2, 3, 4); pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check_eq("rst_pre_view", bus.o_showing_lap, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_async_zero", all_out(), 32'h0);
        #1 rst = 1'b1;
        step();
        check_eq("rst_release", {bus.o_lap_count, bus.o_showing_lap}, {3'd0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
